// File: rtl/reg_store_seq_pkg.sv
// Shared definitions for the register-bank store (and future load) sequencers.
// Register i lives at flat[DATA_W*i +: DATA_W] in the packed register file.
package reg_store_seq_pkg;

  localparam int RS_DATA_W    = 32;
  localparam int RS_NUM_REGS  = 16;
  localparam int RS_ADDR_STEP = 4;
  localparam int RS_IDX_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Drop the lowest set bit of a register mask.
  function automatic logic [RS_NUM_REGS-1:0] clr_lowest(input logic [RS_NUM_REGS-1:0] m);
    return m & (m - 1'b1);
  endfunction

  // LSB position of register idx inside the packed register file.
  function automatic int reg_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/reg_store_seq_lsb_priority_enc16.sv
// Lowest-set-bit priority encoder for a 16-bit register mask.
// valid_o is low for an empty mask, in which case idx_o is 0.
module lsb_priority_enc16 (
  input  logic [15:0] mask_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan downward so the lowest set bit is the last one to win.
    for (int i = 15; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = 4'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_store_seq.sv
// Store-multiple sequencer: snapshots the register file and writes each
// selected register to consecutive addresses over a req/ack memory port.
module reg_store_seq
  import reg_store_seq_pkg::*;
#(
  parameter int DATA_W    = RS_DATA_W,
  parameter int NUM_REGS  = RS_NUM_REGS,
  parameter int ADDR_STEP = RS_ADDR_STEP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_REGS-1:0]        reg_mask,
  input  logic [31:0]                base_addr,
  input  logic [NUM_REGS*DATA_W-1:0] reg_flat,
  output logic [31:0]                mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mem_write,
  input  logic                       mem_ack,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 store_count
);

  state_e                      state_q;
  logic [NUM_REGS*DATA_W-1:0]  snap_q;
  logic [NUM_REGS-1:0]         rem_q;
  logic [31:0]                 addr_q;
  logic [31:0]                 mem_addr_q;
  logic [DATA_W-1:0]           mem_wdata_q;
  logic                        mem_write_q;
  logic                        busy_q;
  logic                        done_q;
  logic [4:0]                  store_count_q;

  logic [NUM_REGS-1:0]         rem_d;
  logic [31:0]                 addr_d;
  logic [NUM_REGS-1:0]         enc_mask;
  logic [NUM_REGS*DATA_W-1:0]  enc_src;
  logic [RS_IDX_W-1:0]         enc_idx;
  logic                        enc_valid;

  function automatic logic [DATA_W-1:0] reg_slice(input logic [NUM_REGS*DATA_W-1:0] flat,
                                                  input logic [RS_IDX_W-1:0] idx);
    return flat[reg_lsb(int'(idx), DATA_W) +: DATA_W];
  endfunction

  assign rem_d  = clr_lowest(rem_q);
  assign addr_d = addr_q + 32'(ADDR_STEP);

  // One encoder serves both the first register (from the live inputs in IDLE)
  // and the next register after an ack (from the snapshot in WRITE), so every
  // output can be registered without a bubble between writes.
  always_comb begin
    enc_mask = rem_d;
    enc_src  = snap_q;
    if (state_q == ST_IDLE) begin
      enc_mask = reg_mask;
      enc_src  = reg_flat;
    end
  end

  lsb_priority_enc16 u_enc (
    .mask_i  (enc_mask),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      snap_q        <= '0;
      rem_q         <= '0;
      addr_q        <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_write_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      store_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_write_q <= 1'b0;
          done_q      <= 1'b0;
          if (start) begin
            store_count_q <= '0;
            busy_q        <= 1'b1;
            if (enc_valid) begin
              snap_q      <= reg_flat;
              rem_q       <= reg_mask;
              addr_q      <= base_addr;
              mem_addr_q  <= base_addr;
              mem_wdata_q <= reg_slice(enc_src, enc_idx);
              mem_write_q <= 1'b1;
              state_q     <= ST_WRITE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_WRITE: begin
          if (mem_ack) begin
            rem_q         <= rem_d;
            addr_q        <= addr_d;
            store_count_q <= store_count_q + 5'd1;
            if (!enc_valid) begin
              mem_write_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              mem_addr_q  <= addr_d;
              mem_wdata_q <= reg_slice(enc_src, enc_idx);
            end
          end
        end

        ST_DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          mem_write_q <= 1'b0;
          state_q     <= ST_IDLE;
        end

        default: begin
          mem_write_q <= 1'b0;
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_write   = mem_write_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign store_count = store_count_q;

endmodule

// File: tb/tb_reg_store_seq.sv
// Randomized bench for reg_store_seq: expected writes are derived from the
// mask/base/register values with a simple list model and checked in order.
module tb_reg_store_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  reg_mask;
  logic [31:0]  base_addr;
  logic [511:0] reg_flat;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_write;
  logic         mem_ack;
  logic         busy;
  logic         done;
  logic [4:0]   store_count;

  int n_checks = 0;
  int n_errors = 0;

  reg_store_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .reg_mask    (reg_mask),
    .base_addr   (base_addr),
    .reg_flat    (reg_flat),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_write   (mem_write),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .done        (done),
    .store_count (store_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_regs();
    for (int k = 0; k < 16; k++) reg_flat[32*k +: 32] = $urandom;
  endtask

  // ack_mode: 0 = always ack, 1 = random ack, 2 = ack after 3 stall cycles.
  task automatic run_cmd(input logic [15:0] mask, input logic [31:0] base,
                         input int ack_mode, input int extra_start_at, input bit scramble);
    logic [31:0]  exp_addr[$];
    logic [31:0]  exp_data[$];
    logic [511:0] snap;
    int           n, writes, cyc, stalls, held;
    bit           got_done, seen_w, ack;
    snap = reg_flat;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        exp_addr.push_back(base + 32'(4 * n));
        exp_data.push_back(snap[32*i +: 32]);
        n++;
      end
    end
    start     = 1'b1;
    reg_mask  = mask;
    base_addr = base;
    mem_ack   = 1'($urandom_range(0, 1));
    step();
    start     = 1'b0;
    reg_mask  = 16'($urandom);
    base_addr = $urandom;
    if (scramble) scramble_regs();
    writes = 0; cyc = 1; stalls = 0; held = 0; got_done = 0; seen_w = 0;
    while (!got_done && cyc < 300) begin
      start = (cyc == extra_start_at);
      if (start) reg_mask = 16'hFFFF;
      if (mem_write) begin
        if (!seen_w) chk("first_latency", 32'(cyc), 32'd1);
        seen_w = 1;
        if (exp_addr.size() == 0) begin
          chk("extra_write", 32'd1, 32'd0);
        end else begin
          chk("wr_addr", mem_addr, exp_addr[0]);
          chk("wr_data", mem_wdata, exp_data[0]);
        end
        chk("busy_in_write", 32'(busy), 32'd1);
        case (ack_mode)
          0:       ack = 1'b1;
          1:       ack = ($urandom_range(0, 2) != 0);
          default: ack = (held == 3);
        endcase
        mem_ack = ack;
        if (ack) begin
          if (exp_addr.size() != 0) begin
            void'(exp_addr.pop_front());
            void'(exp_data.pop_front());
          end
          writes++;
          held = 0;
        end else begin
          held++;
          stalls++;
        end
      end else if (done) begin
        got_done = 1;
        chk("done_count", 32'(store_count), 32'(n));
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_writes", 32'(writes), 32'(n));
        chk("done_cycle", 32'(cyc), 32'(n + 1 + stalls));
        mem_ack = 1'($urandom_range(0, 1));
      end else begin
        chk("gap_no_write_no_done", 32'd0, 32'd1);
      end
      step();
      cyc++;
    end
    if (!got_done) chk("timeout_no_done", 32'd0, 32'd1);
    start   = 1'b0;
    mem_ack = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_write", 32'(mem_write), 32'd0);
    chk("idle_count", 32'(store_count), 32'(n));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
    reg_mask = '0; base_addr = '0;
    scramble_regs();
    step(); step(); step();
    reset = 1'b0;
    step();
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(store_count), 32'd0);

    // Empty mask: immediate done, no writes.
    run_cmd(16'h0000, 32'h1234, 0, 0, 0);

    // Single store of r3.
    reg_flat[96 +: 32] = 32'hDEADBEEF;
    run_cmd(16'h0008, 32'h100, 0, 0, 0);

    // r0, r2, r15 in ascending order.
    reg_flat[0 +: 32] = 32'd1;
    reg_flat[64 +: 32] = 32'd2;
    reg_flat[480 +: 32] = 32'hF;
    run_cmd(16'h8005, 32'h200, 0, 0, 0);

    // Backpressure with register file changing after the start cycle.
    run_cmd(16'h0A11, 32'h300, 2, 0, 1);

    // Address wrap plus a start pulse while busy.
    run_cmd(16'h0003, 32'hFFFFFFFC, 0, 1, 0);

    // Reset during the second of four writes.
    start = 1'b1; reg_mask = 16'h00F0; base_addr = 32'h40; mem_ack = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_second_addr", mem_addr, 32'h44);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_write", 32'(mem_write), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(store_count), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_rst_no_done", 32'(done), 32'd0);
      chk("mid_rst_idle_write", 32'(mem_write), 32'd0);
    end
    mem_ack = 1'b0;
    run_cmd(16'h0C30, 32'h80, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      logic [15:0] m;
      m = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      if (t % 3 == 0) scramble_regs();
      run_cmd(m, $urandom, $urandom_range(0, 2), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      for (int k = 0; k < $urandom_range(0, 2); k++) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
